exe_pipeline_controller: RTL
============================

// Module: exe_pipeline_controller
// PURPOSE
//  Sequences the execute stage and its neighbours in the 5-stage ARM pipeline.
//  - Detects ID-stage data hazards.
//  - Produces forwarding selects for the EX-stage ALU operands.
//  - Freezes the whole pipeline while a MEM-stage SRAM access completes over several cycles.
//  - Flushes IF/ID and ID/EX on a taken branch.
//  - Gates the status-register load so flags update exactly once per instruction.
// PARAMETERS
//  REG_W     4  register-address width
//  MEM_WAIT  4  SRAM access cycles, >=1 (0 is illegal; elaboration-time assert)
//  FWD_EN    1  1: forwarding on, stall only on load-use; 0: stall on any RAW
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  idSrc1       in   REG_W  ID-stage Rn
//  idSrc2       in   REG_W  ID-stage Rm/Rd (store)
//  idTwoSrc     in   1      ID instruction reads idSrc2
//  exSrc1       in   REG_W  EX-stage Rn
//  exSrc2       in   REG_W  EX-stage second source
//  exDest       in   REG_W  EX-stage destination
//  exWbEn       in   1      EX-stage write-back enable
//  exMemREn     in   1      EX-stage instruction is a load
//  memDest      in   REG_W  MEM-stage destination
//  memWbEn      in   1      MEM-stage write-back enable
//  memREn       in   1      MEM-stage load
//  memWEn       in   1      MEM-stage store
//  wbDest       in   REG_W  WB-stage destination
//  wbWbEn       in   1      WB-stage write-back enable
//  branchTaken  in   1      EX-stage taken branch
//  ldStatusIn   in   1      EX-stage S-bit
//  freeze       out  1      hold all pipeline registers and PC
//  hazard       out  1      hold PC and IF/ID, insert bubble into ID/EX
//  flushIfId    out  1      clear IF/ID
//  flushIdEx    out  1      clear ID/EX control bits
//  sramStart    out  1      start SRAM access, sampled by SRAM at next edge
//  memRdy       out  1      SRAM data valid; MEM/WB latches read data
//  selSrc1      out  2      forwarding select, ALU operand val1
//  selSrc2      out  2      forwarding select, ALU operand valRm
//  ldStatusOut  out  1      gated status-register load
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, DONE. Counter cnt has width clog2(MEM_WAIT+1).
//  - Reset: state=IDLE, cnt=0. While rst=1, sramStart, memRdy, flushIfId and flushIdEx are forced 0.
//  - memReq = memREn | memWEn.
//  - IDLE & memReq: sramStart=1 and freeze=1 (combinational). Next state ACCESS, cnt<=MEM_WAIT-1.
//  - ACCESS: freeze=1. When cnt!=0, cnt decrements. When cnt==0, next state DONE.
//  - DONE: freeze=0, memRdy=1. Next state IDLE unconditionally; memReq is ignored in DONE.
//  - A memory instruction occupies MEM for MEM_WAIT+2 cycles.
//  - Back-to-back memory ops therefore have one unfrozen cycle between accesses.
//  - rst in ACCESS or DONE: state returns to IDLE at that edge. No memRdy is issued; the access is abandoned.
//  Hazard detection (combinational):
//  - m1 = idSrc1 matches dest; m2 = idTwoSrc & (idSrc2 matches dest).
//  - FWD_EN=1: hazard = exWbEn & exMemREn & (m1|m2 vs exDest).
//  - FWD_EN=0: hazard = (exWbEn & (m1|m2 vs exDest)) | (memWbEn & (m1|m2 vs memDest)).
//  Flush:
//  - flushIfId = branchTaken & ~freeze.
//  - flushIdEx = (branchTaken | hazard) & ~freeze.
//  - branchTaken has priority over hazard; both produce the same flushIdEx.
//  Forwarding (FWD_EN=1 only; otherwise selects are 00):
//  - Encoding: 00 register file, 01 MEM-stage ALU result, 10 WB-stage value.
//  - MEM match beats WB match.
//  - A match requires the corresponding WbEn to be 1.
//  ldStatusOut = ldStatusIn & ~freeze & ~rst.
// STRUCTURE
//  Shared package arm_pkg holds:
//  - exe_ctrl_state_t enum {IDLE, ACCESS, DONE}.
//  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//  One sub-module, forwarding_unit, computes selSrc1 and selSrc2 combinationally.
//  The FSM, counter, hazard logic and flush logic stay in this module.
// TESTING
//  1. MEM_WAIT=4; load reaches MEM -> freeze=1 for 5 cycles, sramStart for 1 cycle, then memRdy=1 with freeze=0.
//  2. Load R3 in EX; ID reads idSrc1=3 with FWD_EN=1 -> hazard=1, flushIdEx=1 for 1 cycle. ADD R3 in EX instead -> hazard=0.
//  3. FWD_EN=1: exSrc1=5, memDest=5, memWbEn=1, wbDest=5, wbWbEn=1 -> selSrc1=01. With memWbEn=0 -> selSrc1=10.
//  4. branchTaken=1 during a SRAM freeze -> no flush while frozen; flushIfId=flushIdEx=1 in the DONE cycle.
//  5. ldStatusIn=1 held for 6 cycles across a freeze -> ldStatusOut=1 only in unfrozen cycles.
//  6. rst asserted in ACCESS with cnt=2 -> next cycle state=IDLE, freeze=0, memRdy never pulses.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared pipeline-controller types (FSM state, forwarding select codes)
package arm_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } exe_ctrl_state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
endpackage

// File: rtl/exe_pipeline_controller_if.sv
// exe_pipeline_controller_if: pipeline-stage hazard/forwarding/memory control bundle
//   master: pipeline datapath side, drives stage register fields, receives controls
//   slave : controller side, reads stage register fields, drives freeze/flush/forwarding
interface exe_pipeline_controller_if #(parameter int REG_W = 4);
  logic [REG_W-1:0] idSrc1, idSrc2, exSrc1, exSrc2, exDest, memDest, wbDest;
  logic idTwoSrc, exWbEn, exMemREn, memWbEn, memREn, memWEn, wbWbEn;
  logic branchTaken, ldStatusIn;
  logic freeze, hazard, flushIfId, flushIdEx, sramStart, memRdy, ldStatusOut;
  logic [1:0] selSrc1, selSrc2;
  modport master (
    output idSrc1, idSrc2, idTwoSrc, exSrc1, exSrc2, exDest, exWbEn, exMemREn,
           memDest, memWbEn, memREn, memWEn, wbDest, wbWbEn, branchTaken, ldStatusIn,
    input  freeze, hazard, flushIfId, flushIdEx, sramStart, memRdy, selSrc1, selSrc2,
           ldStatusOut
  );
  modport slave (
    input  idSrc1, idSrc2, idTwoSrc, exSrc1, exSrc2, exDest, exWbEn, exMemREn,
           memDest, memWbEn, memREn, memWEn, wbDest, wbWbEn, branchTaken, ldStatusIn,
    output freeze, hazard, flushIfId, flushIdEx, sramStart, memRdy, selSrc1, selSrc2,
           ldStatusOut
  );
endinterface

// File: rtl/forwarding_unit.sv
// forwarding_unit: EX-stage ALU operand forwarding selects
//   exSrc1/exSrc2       EX-stage source registers
//   memDest/memWbEn     MEM-stage destination and write-back enable
//   wbDest/wbWbEn       WB-stage destination and write-back enable
//   selSrc1/selSrc2     00 register file, 01 MEM result, 10 WB value
module forwarding_unit
  import arm_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int FWD_EN = 1
) (
  input  logic [REG_W-1:0] exSrc1,
  input  logic [REG_W-1:0] exSrc2,
  input  logic [REG_W-1:0] memDest,
  input  logic             memWbEn,
  input  logic [REG_W-1:0] wbDest,
  input  logic             wbWbEn,
  output logic [1:0]       selSrc1,
  output logic [1:0]       selSrc2
);
  // the MEM stage holds the younger result, so it wins over WB
  assign selSrc1 = (FWD_EN == 0)                  ? FWD_RF  :
                   (memWbEn && exSrc1 == memDest) ? FWD_MEM :
                   (wbWbEn  && exSrc1 == wbDest)  ? FWD_WB  : FWD_RF;
  assign selSrc2 = (FWD_EN == 0)                  ? FWD_RF  :
                   (memWbEn && exSrc2 == memDest) ? FWD_MEM :
                   (wbWbEn  && exSrc2 == wbDest)  ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/exe_pipeline_controller.sv
// exe_pipeline_controller: execute-stage sequencing for the 5-stage ARM pipeline
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        slave side of exe_pipeline_controller_if: stage register fields in;
//              freeze/hazard/flush, SRAM start/ready, forwarding selects and
//              gated status load out
module exe_pipeline_controller
  import arm_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int MEM_WAIT = 4,
  parameter int FWD_EN   = 1
) (
  input logic clk,
  input logic rst,
  exe_pipeline_controller_if.slave bus
);
  localparam int CW = $clog2(MEM_WAIT + 1);
  if (MEM_WAIT < 1) begin : g_bad_wait
    $error("exe_pipeline_controller: MEM_WAIT must be >= 1");
  end
  exe_ctrl_state_t state;
  logic [CW-1:0] cnt;
  logic memReq, frz, haz, exHit, memHit;
  assign memReq = bus.memREn | bus.memWEn;
  // freeze rises combinationally with the request so the load never slips past MEM
  assign frz = (state == IDLE && memReq) || state == ACCESS;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (memReq) begin
        state <= ACCESS;
        cnt   <= CW'(MEM_WAIT - 1);
      end
    end else if (state == ACCESS) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      else state <= DONE;
    end else begin
      state <= IDLE;
    end
  end
  assign exHit  = bus.idSrc1 == bus.exDest  || (bus.idTwoSrc && bus.idSrc2 == bus.exDest);
  assign memHit = bus.idSrc1 == bus.memDest || (bus.idTwoSrc && bus.idSrc2 == bus.memDest);
  // with forwarding only a load in EX cannot be bypassed in time
  assign haz = (FWD_EN != 0) ? (bus.exWbEn && bus.exMemREn && exHit)
                             : ((bus.exWbEn && exHit) || (bus.memWbEn && memHit));
  assign bus.freeze      = frz;
  assign bus.hazard      = haz;
  assign bus.sramStart   = !rst && state == IDLE && memReq;
  assign bus.memRdy      = !rst && state == DONE;
  assign bus.flushIfId   = !rst && !frz && bus.branchTaken;
  assign bus.flushIdEx   = !rst && !frz && (bus.branchTaken || haz);
  assign bus.ldStatusOut = bus.ldStatusIn && !frz && !rst;
  forwarding_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd (
    .exSrc1  (bus.exSrc1),
    .exSrc2  (bus.exSrc2),
    .memDest (bus.memDest),
    .memWbEn (bus.memWbEn),
    .wbDest  (bus.wbDest),
    .wbWbEn  (bus.wbWbEn),
    .selSrc1 (bus.selSrc1),
    .selSrc2 (bus.selSrc2)
  );
endmodule
